// File: rtl/uop_pkg.sv
// Shared micro-op types for the rename/dispatch slice: uop tags, the
// dispatch capability-barrier state, and the queue entry layout.
package uop_pkg;

  // Micro-op class tag carried from rename to the backend.
  typedef enum logic [3:0] {
    UOP_NOP       = 4'd0,
    UOP_ALU       = 4'd1,
    UOP_MUL       = 4'd2,
    UOP_DIV       = 4'd3,
    UOP_LOAD      = 4'd4,
    UOP_STORE     = 4'd5,
    UOP_BRANCH    = 4'd6,
    UOP_JUMP      = 4'd7,
    UOP_FPU       = 4'd8,
    UOP_CSR       = 4'd9,
    UOP_FENCE     = 4'd10,
    UOP_AMO       = 4'd11,
    UOP_CAP_JUMP  = 4'd12,
    UOP_CAP_RET   = 4'd13,
    UOP_CAP_LOAD  = 4'd14,
    UOP_CAP_STORE = 4'd15
  } uop_tag_t;

  // Capability barrier: idle, or one capability uop owned by the backend.
  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_WAIT = 1'b1
  } dispatch_cap_state_e;

  // One dispatch queue slot.
  typedef struct packed {
    uop_tag_t tag;
    logic     is_cap;
  } dq_entry_t;

  // Rename reports 0..3 lanes; 3 is an over-report and means both lanes.
  function automatic logic [1:0] lanes_to_write(input logic [1:0] uop_count);
    return (uop_count == 2'd3) ? 2'd2 : uop_count;
  endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Rename-side and backend-side handshake bundle of the dispatch queue.
// master: the surrounding pipeline (rename + backend); slave: the queue.
interface dispatch_queue_if;
  import uop_pkg::*;

  logic       rename_valid_i;
  uop_tag_t   rename_uop0_i;
  uop_tag_t   rename_uop1_i;
  logic [1:0] rename_uop_count_i;
  logic [1:0] rename_lane_is_cap_i;
  logic       rename_ready_o;

  logic       issue_valid_o;
  uop_tag_t   issue_uop_o;
  logic       issue_is_cap_o;
  logic       issue_ready_i;

  logic       cap_done_i;
  logic       flush_i;

  modport master (
    output rename_valid_i, rename_uop0_i, rename_uop1_i,
           rename_uop_count_i, rename_lane_is_cap_i,
           issue_ready_i, cap_done_i, flush_i,
    input  rename_ready_o, issue_valid_o, issue_uop_o, issue_is_cap_o
  );

  modport slave (
    input  rename_valid_i, rename_uop0_i, rename_uop1_i,
           rename_uop_count_i, rename_lane_is_cap_i,
           issue_ready_i, cap_done_i, flush_i,
    output rename_ready_o, issue_valid_o, issue_uop_o, issue_is_cap_o
  );

endinterface

// File: rtl/dispatch_ring_2w1r.sv
// Two-write / one-read ring buffer with head, tail and count registers.
// Lane 0 lands at tail, lane 1 at tail+1; flush empties the ring but keeps
// stale storage, which is harmless because count gates every read.
module dispatch_ring_2w1r #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [1:0]                 wr_n,
  input  logic [WIDTH-1:0]           wr_data0,
  input  logic [WIDTH-1:0]           wr_data1,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    head_reg;
  logic [AW-1:0]    tail_reg;
  logic [CW-1:0]    count_reg;

  logic [AW-1:0]    tail_plus1;
  logic [CW-1:0]    n_wr;
  logic [CW-1:0]    n_pop;

  assign tail_plus1 = tail_reg + AW'(1);
  assign n_wr       = wr_en ? CW'(wr_n) : '0;
  assign n_pop      = CW'(pop);

  // Pointer/count update and lane writes; flush wins over write and pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (wr_en && wr_n != 2'd0) begin
        mem_reg[tail_reg] <= wr_data0;
      end
      if (wr_en && wr_n == 2'd2) begin
        mem_reg[tail_plus1] <= wr_data1;
      end
      tail_reg  <= tail_reg + AW'(n_wr);
      head_reg  <= head_reg + AW'(pop);
      count_reg <= count_reg + n_wr - n_pop;
    end
  end

  // Head is read straight from storage so a freshly written entry is
  // visible the cycle after its write edge.
  assign rd_data = mem_reg[head_reg];
  assign count   = count_reg;

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch queue between rename and the backend. Accepts up to
// two uops per cycle, issues one per cycle, and holds a capability uop at
// the head while a previous capability uop is still in the backend.
module dispatch_queue
  import uop_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int MAX_UOPS = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  dispatch_queue_if.slave            dq,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic [15:0]                cap_stall_count_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = $bits(dq_entry_t);

  logic [CW-1:0]       count;
  logic [EW-1:0]       head_bits;
  dq_entry_t           head_entry;
  uop_tag_t            lane_tag   [2];
  dq_entry_t           lane_entry [2];
  logic [1:0]          n_lanes;
  logic                rename_ready;
  logic                wr_en;
  logic                issue_valid;
  logic                pop_fire;
  logic                stall_cond;
  dispatch_cap_state_e cap_state_reg;
  logic [15:0]         stall_count_reg;

  assign lane_tag[0] = dq.rename_uop0_i;
  assign lane_tag[1] = dq.rename_uop1_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign lane_entry[gi] = '{tag: lane_tag[gi], is_cap: dq.rename_lane_is_cap_i[gi]};
  end

  // Ready depends on registered count only, so rename never sees a path
  // from the backend handshake.
  assign rename_ready = (count <= CW'(DEPTH - MAX_UOPS));
  assign n_lanes      = lanes_to_write(dq.rename_uop_count_i);
  assign wr_en        = dq.rename_valid_i && rename_ready;

  assign head_entry   = head_bits;
  assign issue_valid  = (count != '0) && !(head_entry.is_cap && cap_state_reg == CAP_WAIT);
  // A flush cancels a same-cycle pop, including its effect on the barrier.
  assign pop_fire     = issue_valid && dq.issue_ready_i && !dq.flush_i;
  assign stall_cond   = (count != '0) && head_entry.is_cap && (cap_state_reg == CAP_WAIT);

  dispatch_ring_2w1r #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ring (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush    (dq.flush_i),
    .wr_en    (wr_en),
    .wr_n     (n_lanes),
    .wr_data0 (lane_entry[0]),
    .wr_data1 (lane_entry[1]),
    .pop      (pop_fire),
    .rd_data  (head_bits),
    .count    (count)
  );

  // Capability barrier FSM; flush leaves it alone since an issued
  // capability uop still belongs to the backend.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_state_reg <= CAP_IDLE;
    end else begin
      case (cap_state_reg)
        CAP_IDLE: if (pop_fire && head_entry.is_cap) cap_state_reg <= CAP_WAIT;
        CAP_WAIT: if (dq.cap_done_i)                 cap_state_reg <= CAP_IDLE;
        default:                                     cap_state_reg <= CAP_IDLE;
      endcase
    end
  end

  // Saturating count of cycles the head sat behind the barrier.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_count_reg <= '0;
    end else if (stall_cond && stall_count_reg != 16'hFFFF) begin
      stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

  assign dq.rename_ready_o = rename_ready;
  assign dq.issue_valid_o  = issue_valid;
  assign dq.issue_uop_o    = head_entry.tag;
  assign dq.issue_is_cap_o = head_entry.is_cap;
  assign occupancy_o       = count;
  assign cap_stall_count_o = stall_count_reg;

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue: reset, basic flow, fill/ready,
// capability barrier, flush in CAP_WAIT, overlap across wrap, count edges,
// and reset out of CAP_WAIT.
module tb_dispatch_queue;
  import uop_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  occ;
  logic [15:0] stall;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  dispatch_queue_if dq_if ();

  dispatch_queue #(
    .DEPTH    (8),
    .MAX_UOPS (2)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .dq                (dq_if),
    .occupancy_o       (occ),
    .cap_stall_count_o (stall)
  );

  // One line per issue handshake.
  always @(negedge clk) begin
    if (!rst && dq_if.issue_valid_o && dq_if.issue_ready_i && !dq_if.flush_i)
      $display("issue tag=%0d cap=%0b occ=%0d stall=%0d",
               dq_if.issue_uop_o, dq_if.issue_is_cap_o, occ, stall);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_group(input uop_tag_t u0, input uop_tag_t u1,
                             input logic [1:0] cnt, input logic [1:0] cap);
    dq_if.rename_valid_i       = 1'b1;
    dq_if.rename_uop0_i        = u0;
    dq_if.rename_uop1_i        = u1;
    dq_if.rename_uop_count_i   = cnt;
    dq_if.rename_lane_is_cap_i = cap;
  endtask

  task automatic drive_idle;
    dq_if.rename_valid_i       = 1'b0;
    dq_if.rename_uop0_i        = UOP_NOP;
    dq_if.rename_uop1_i        = UOP_NOP;
    dq_if.rename_uop_count_i   = 2'd0;
    dq_if.rename_lane_is_cap_i = 2'b00;
    dq_if.cap_done_i           = 1'b0;
    dq_if.flush_i              = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive_idle();
    dq_if.issue_ready_i = 1'b0;
    tick();
    tick();
    total++; if (dq_if.rename_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", dq_if.rename_ready_o); end
    total++; if (dq_if.issue_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", dq_if.issue_valid_o); end
    total++; if (dq_if.issue_uop_o !== UOP_NOP) begin bad++; $display("FAIL reset_uop got=%0d want=0", dq_if.issue_uop_o); end
    total++; if (dq_if.issue_is_cap_o !== 1'b0) begin bad++; $display("FAIL reset_is_cap got=%b want=0", dq_if.issue_is_cap_o); end
    total++; if (occ !== 4'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occ); end
    total++; if (stall !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0d want=0", stall); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    drive_group(UOP_ALU, UOP_MUL, 2'd2, 2'b00);
    tick();
    drive_idle();
    total++; if (occ !== 4'd2) begin bad++; $display("FAIL basic_occ2 got=%0d want=2", occ); end
    total++; if (dq_if.issue_valid_o !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", dq_if.issue_valid_o); end
    total++; if (dq_if.issue_uop_o !== UOP_ALU) begin bad++; $display("FAIL basic_head0 got=%0d want=%0d", dq_if.issue_uop_o, UOP_ALU); end
    total++; if (dq_if.issue_is_cap_o !== 1'b0) begin bad++; $display("FAIL basic_is_cap got=%b want=0", dq_if.issue_is_cap_o); end
    dq_if.issue_ready_i = 1'b1;
    tick();
    total++; if (occ !== 4'd1) begin bad++; $display("FAIL basic_occ1 got=%0d want=1", occ); end
    total++; if (dq_if.issue_uop_o !== UOP_MUL) begin bad++; $display("FAIL basic_head1 got=%0d want=%0d", dq_if.issue_uop_o, UOP_MUL); end
    tick();
    total++; if (occ !== 4'd0) begin bad++; $display("FAIL basic_occ0 got=%0d want=0", occ); end
    total++; if (dq_if.issue_valid_o !== 1'b0) begin bad++; $display("FAIL basic_empty_valid got=%b want=0", dq_if.issue_valid_o); end
    dq_if.issue_ready_i = 1'b0;
  endtask

  task automatic test_fill;
    int   exp_occ [3] = '{3, 5, 7};
    logic exp_rdy [3] = '{1'b1, 1'b1, 1'b0};
    drive_group(UOP_ALU, UOP_NOP, 2'd1, 2'b00);
    tick();
    total++; if (occ !== 4'd1) begin bad++; $display("FAIL fill_occ1 got=%0d want=1", occ); end
    for (int i = 0; i < 3; i++) begin
      drive_group(UOP_MUL, UOP_DIV, 2'd2, 2'b00);
      tick();
      total++; if (occ !== 4'(exp_occ[i])) begin bad++; $display("FAIL fill_occ step=%0d got=%0d want=%0d", i, occ, exp_occ[i]); end
      total++; if (dq_if.rename_ready_o !== exp_rdy[i]) begin bad++; $display("FAIL fill_ready step=%0d got=%b want=%b", i, dq_if.rename_ready_o, exp_rdy[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (occ !== 4'd7) begin bad++; $display("FAIL fill_hold step=%0d got=%0d want=7", i, occ); end
      total++; if (dq_if.rename_ready_o !== 1'b0) begin bad++; $display("FAIL fill_hold_ready step=%0d got=%b want=0", i, dq_if.rename_ready_o); end
    end
    drive_idle();
    dq_if.flush_i = 1'b1;
    tick();
    dq_if.flush_i = 1'b0;
    total++; if (occ !== 4'd0) begin bad++; $display("FAIL fill_flush_occ got=%0d want=0", occ); end
    total++; if (dq_if.rename_ready_o !== 1'b1) begin bad++; $display("FAIL fill_flush_ready got=%b want=1", dq_if.rename_ready_o); end
  endtask

  task automatic test_cap_barrier;
    dq_if.issue_ready_i = 1'b1;
    drive_group(UOP_CAP_JUMP, UOP_CAP_RET, 2'd2, 2'b11);
    tick();
    drive_idle();
    total++; if (dq_if.issue_valid_o !== 1'b1) begin bad++; $display("FAIL cap_jump_valid got=%b want=1", dq_if.issue_valid_o); end
    total++; if (dq_if.issue_uop_o !== UOP_CAP_JUMP) begin bad++; $display("FAIL cap_jump_uop got=%0d want=%0d", dq_if.issue_uop_o, UOP_CAP_JUMP); end
    total++; if (dq_if.issue_is_cap_o !== 1'b1) begin bad++; $display("FAIL cap_jump_is_cap got=%b want=1", dq_if.issue_is_cap_o); end
    tick();
    total++; if (dq_if.issue_valid_o !== 1'b0) begin bad++; $display("FAIL cap_ret_blocked got=%b want=0", dq_if.issue_valid_o); end
    total++; if (dq_if.issue_uop_o !== UOP_CAP_RET) begin bad++; $display("FAIL cap_ret_head got=%0d want=%0d", dq_if.issue_uop_o, UOP_CAP_RET); end
    total++; if (occ !== 4'd1) begin bad++; $display("FAIL cap_occ1 got=%0d want=1", occ); end
    total++; if (stall !== 16'd0) begin bad++; $display("FAIL cap_stall0 got=%0d want=0", stall); end
    tick();
    total++; if (stall !== 16'd1) begin bad++; $display("FAIL cap_stall1 got=%0d want=1", stall); end
    tick();
    total++; if (stall !== 16'd2) begin bad++; $display("FAIL cap_stall2 got=%0d want=2", stall); end
    dq_if.cap_done_i = 1'b1;
    #1;
    total++; if (dq_if.issue_valid_o !== 1'b0) begin bad++; $display("FAIL cap_done_same_cycle got=%b want=0", dq_if.issue_valid_o); end
    tick();
    dq_if.cap_done_i = 1'b0;
    total++; if (dq_if.issue_valid_o !== 1'b1) begin bad++; $display("FAIL cap_ret_release got=%b want=1", dq_if.issue_valid_o); end
    total++; if (stall !== 16'd3) begin bad++; $display("FAIL cap_stall3 got=%0d want=3", stall); end
    tick();
    total++; if (occ !== 4'd0) begin bad++; $display("FAIL cap_ret_popped got=%0d want=0", occ); end
    tick();
    total++; if (stall !== 16'd3) begin bad++; $display("FAIL cap_stall_empty got=%0d want=3", stall); end
    dq_if.issue_ready_i = 1'b0;
  endtask

  task automatic test_flush_in_wait;
    drive_group(UOP_ALU, UOP_CAP_JUMP, 2'd2, 2'b10);
    dq_if.flush_i = 1'b1;
    tick();
    drive_idle();
    total++; if (occ !== 4'd0) begin bad++; $display("FAIL flush_occ got=%0d want=0", occ); end
    total++; if (dq_if.issue_valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", dq_if.issue_valid_o); end
    drive_group(UOP_CAP_JUMP, UOP_NOP, 2'd1, 2'b01);
    tick();
    drive_idle();
    total++; if (occ !== 4'd1) begin bad++; $display("FAIL flush_refill_occ got=%0d want=1", occ); end
    total++; if (dq_if.issue_valid_o !== 1'b0) begin bad++; $display("FAIL flush_still_wait got=%b want=0", dq_if.issue_valid_o); end
    total++; if (stall !== 16'd3) begin bad++; $display("FAIL flush_stall_kept got=%0d want=3", stall); end
    tick();
    total++; if (stall !== 16'd4) begin bad++; $display("FAIL flush_stall4 got=%0d want=4", stall); end
    dq_if.cap_done_i = 1'b1;
    tick();
    dq_if.cap_done_i = 1'b0;
    total++; if (dq_if.issue_valid_o !== 1'b1) begin bad++; $display("FAIL flush_release got=%b want=1", dq_if.issue_valid_o); end
    total++; if (stall !== 16'd5) begin bad++; $display("FAIL flush_stall5 got=%0d want=5", stall); end
    dq_if.issue_ready_i = 1'b1;
    tick();
    dq_if.issue_ready_i = 1'b0;
    total++; if (occ !== 4'd0) begin bad++; $display("FAIL flush_drain got=%0d want=0", occ); end
    dq_if.cap_done_i = 1'b1;
    tick();
    dq_if.cap_done_i = 1'b0;
  endtask

  task automatic test_back_to_back;
    uop_tag_t seq [11] = '{UOP_ALU, UOP_MUL, UOP_DIV, UOP_LOAD, UOP_STORE, UOP_BRANCH,
                           UOP_JUMP, UOP_FPU, UOP_CSR, UOP_FENCE, UOP_AMO};
    drive_group(seq[0], seq[1], 2'd2, 2'b00);
    tick();
    drive_group(seq[2], UOP_NOP, 2'd1, 2'b00);
    tick();
    total++; if (occ !== 4'd3) begin bad++; $display("FAIL b2b_occ3 got=%0d want=3", occ); end
    dq_if.issue_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_group(seq[3+2*i], seq[4+2*i], 2'd2, 2'b00);
      total++; if (dq_if.issue_uop_o !== seq[i]) begin bad++; $display("FAIL b2b_head step=%0d got=%0d want=%0d", i, dq_if.issue_uop_o, seq[i]); end
      tick();
      total++; if (occ !== 4'(4 + i)) begin bad++; $display("FAIL b2b_occ step=%0d got=%0d want=%0d", i, occ, 4 + i); end
    end
    drive_idle();
    for (int j = 4; j < 11; j++) begin
      total++; if (dq_if.issue_uop_o !== seq[j] || dq_if.issue_valid_o !== 1'b1) begin bad++; $display("FAIL b2b_drain idx=%0d got=%0d/%b want=%0d/1", j, dq_if.issue_uop_o, dq_if.issue_valid_o, seq[j]); end
      tick();
    end
    total++; if (occ !== 4'd0) begin bad++; $display("FAIL b2b_empty got=%0d want=0", occ); end
    dq_if.issue_ready_i = 1'b0;
  endtask

  task automatic test_count_edges;
    drive_group(UOP_ALU, UOP_MUL, 2'd0, 2'b00);
    dq_if.cap_done_i = 1'b1;
    tick();
    drive_idle();
    total++; if (occ !== 4'd0) begin bad++; $display("FAIL cnt0_occ got=%0d want=0", occ); end
    drive_group(UOP_CAP_LOAD, UOP_CAP_STORE, 2'd3, 2'b11);
    tick();
    drive_idle();
    total++; if (occ !== 4'd2) begin bad++; $display("FAIL cnt3_occ got=%0d want=2", occ); end
    total++; if (dq_if.issue_valid_o !== 1'b1) begin bad++; $display("FAIL idle_done_ignored got=%b want=1", dq_if.issue_valid_o); end
    total++; if (dq_if.issue_uop_o !== UOP_CAP_LOAD) begin bad++; $display("FAIL cnt3_head got=%0d want=%0d", dq_if.issue_uop_o, UOP_CAP_LOAD); end
  endtask

  task automatic test_mid_reset;
    dq_if.issue_ready_i = 1'b1;
    tick();
    dq_if.issue_ready_i = 1'b0;
    total++; if (dq_if.issue_valid_o !== 1'b0 || dq_if.issue_uop_o !== UOP_CAP_STORE) begin bad++; $display("FAIL mrst_blocked got=%b/%0d want=0/%0d", dq_if.issue_valid_o, dq_if.issue_uop_o, UOP_CAP_STORE); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (occ !== 4'd0) begin bad++; $display("FAIL mrst_occ got=%0d want=0", occ); end
    total++; if (stall !== 16'd0) begin bad++; $display("FAIL mrst_stall got=%0d want=0", stall); end
    drive_group(UOP_CAP_JUMP, UOP_NOP, 2'd1, 2'b01);
    tick();
    drive_idle();
    total++; if (dq_if.issue_valid_o !== 1'b1) begin bad++; $display("FAIL mrst_fsm_idle got=%b want=1", dq_if.issue_valid_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_cap_barrier();
    test_flush_in_wait();
    test_back_to_back();
    test_count_edges();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

Buffers micro-ops accepted from the rename stage (up to two per cycle, with per-lane capability flags) and issues them in program order, one per cycle, to the backend over a valid/ready handshake. Sits directly downstream of rename and consumes its lane tags and `lane_is_capability` vector. Enforces a capability barrier: at most one capability micro-op is outstanding in the backend, and the next one is held at the queue head until the backend signals completion.

## Interface
- `DEPTH`, 8: queue entries; power of two, ≥ 4.
- `MAX_UOPS`, 2: rename lanes per cycle; fixed at 2 in this version.

- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `rename_valid_i`  in  1  rename group valid.
- `rename_uop0_i`  in  `uop_pkg::uop_tag_t`  lane 0 tag (oldest).
- `rename_uop1_i`  in  `uop_pkg::uop_tag_t`  lane 1 tag.
- `rename_uop_count_i`  in  2  valid lanes, 0..2; value 3 is treated as 2.
- `rename_lane_is_cap_i`  in  2  per-lane capability flag from rename.
- `rename_ready_o`  out  1  queue can accept a full group.
- `issue_valid_o`  out  1  head entry offered to backend.
- `issue_uop_o`  out  `uop_tag_t`  head tag.
- `issue_is_cap_o`  out  1  head is a capability uop.
- `issue_ready_i`  in  1  backend accepts head.
- `cap_done_i`  in  1  backend retired the outstanding capability uop.
- `flush_i`  in  1  discard all queued entries.
- `occupancy_o`  out  $clog2(DEPTH+1)  entries held.
- `cap_stall_count_o`  out  16  cycles the head was blocked by the barrier.

## Operation
- Storage: ring buffer of `{tag, is_cap}`; head pointer, tail pointer, and count registers.
- `rename_ready_o = (DEPTH - count) >= 2`, from registered count only; no combinational path from `issue_ready_i` or `rename_valid_i`.
- Enqueue when `rename_valid_i && rename_ready_o`:
  - Write n = min(count_i, 2) entries: lane 0 at tail, lane 1 at tail+1.
  - Tail advances by n. n = 0 is a legal no-op.
- Issue:
  - `issue_valid_o = (count != 0) && !(head.is_cap && cap_state == CAP_WAIT)`.
  - Pop when `issue_valid_o && issue_ready_i`.
  - `issue_uop_o` and `issue_is_cap_o` always show the head entry, even when invalid.
- Capability FSM, two states:
  - CAP_IDLE → CAP_WAIT when a capability entry is popped.
  - CAP_WAIT → CAP_IDLE on `cap_done_i`.
  - `cap_done_i` in CAP_IDLE is ignored.
- Barrier counter: `cap_stall_count_o` increments when `count != 0`, head is cap, and state is CAP_WAIT. It saturates at 0xFFFF.
- Same-cycle enqueue and pop: count is updated by +n−pop.
- Flush:
  - Sets head, tail, and count to 0. It has priority over a same-cycle enqueue or pop; neither takes effect.
  - Leaves the FSM unchanged, because an already-issued capability uop is still owned by the backend.
  - Does not clear the stall counter.
- Pointer arithmetic is modulo DEPTH; count never exceeds DEPTH because of the ready rule.

## Timing
- Reset values:
  - `rename_ready_o` = 1.
  - `issue_valid_o` = 0.
  - `issue_uop_o` = `'0`, `issue_is_cap_o` = 0.
  - `occupancy_o` = 0, `cap_stall_count_o` = 0.
  - FSM = CAP_IDLE; storage cleared.
- Reset mid-operation discards everything, including CAP_WAIT.
- Enqueue-to-issue latency: 1 cycle. An entry written at edge k is visible at the head after edge k if the queue was empty.
- Issue throughput: 1 per cycle. Accept throughput: 2 per cycle while ≥ 2 entries are free.
- `cap_done_i` at edge k allows a waiting capability head to assert `issue_valid_o` in cycle k+1, never in the same cycle.
- Back-to-back capability uops therefore issue at least 2 cycles apart, plus the backend latency.
- `issue_valid_o` may drop without handshake only by flush or reset.

## Structure
- Add `dispatch_cap_state_e` (CAP_IDLE, CAP_WAIT) to `uop_pkg`, next to `uop_tag_t`.
- Sub-module `dispatch_ring_2w1r`: a parameterised 2-write/1-read ring buffer with pointers, count, and flush.
- The top level adds the ready logic, the capability FSM, and the stall counter.

## Test plan
- Reset, then a group of count=2 {ALU, ALU} followed by idle: `occupancy_o` reads 2. With `issue_ready_i` = 1, two issues occur on consecutive cycles and `occupancy_o` reaches 0.
- Fill with count=2 groups and `issue_ready_i` = 0: `rename_ready_o` drops at occupancy 7 (DEPTH=8). Further valid groups are not written; occupancy stays ≤ 8.
- Enqueue {UOP_CAP_JUMP, UOP_CAP_RET} with the backend always ready: JUMP issues. RET is blocked with `issue_valid_o` = 0 and `cap_stall_count_o` incrementing. `cap_done_i` pulsed at cycle 5 lets RET issue at cycle 6.
- Same-cycle enqueue of 2 and pop of 1 from occupancy 3 gives occupancy 4. Repeat across pointer wrap and check order preserved.
- `flush_i` in the same cycle as a valid group while in CAP_WAIT: occupancy is 0 and the group is dropped. The FSM stays CAP_WAIT until `cap_done_i`.
- `cap_done_i` pulsed in CAP_IDLE and `rename_uop_count_i` = 0 or 3: no state change for the pulse and the count-0 group; count 3 enqueues exactly 2 entries.
